// File: rtl/gate_type_detector.sv
// Identifies which selectable-gate encoding (AND/XOR/XNOR/OR) a black-box N-input gate implements
// by sweeping every input vector and discarding the encodings that disagree with any sampled output.
module gate_type_detector #(
  parameter int N      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [N-1:0] probe_out,
  input  logic         probe_in,
  output logic         busy,
  output logic         done,
  output logic         type_valid,
  output logic [1:0]   gate_type,
  output logic [3:0]   candidates
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [N-1:0] LAST_VEC = '1;

  // A one-input gate cannot tell AND, OR and XOR apart, so narrow widths are refused.
  if (N < 2 || N > 8) begin : g_bad_width
    $error("gate_type_detector: N must be in 2..8");
  end

  typedef enum logic [1:0] {IDLE, WAIT, FINISH} state_t;

  state_t          state, state_n;
  logic [N-1:0]    vec, vec_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      cand, cand_n;
  logic [3:0]      cands_n;
  logic            tv_n;
  logic [1:0]      gt_n;
  logic [3:0]      expected;
  logic [3:0]      sampled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      cand       <= 4'b0000;
      candidates <= 4'b0000;
      type_valid <= 1'b0;
      gate_type  <= 2'b00;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      cand       <= cand_n;
      candidates <= cands_n;
      type_valid <= tv_n;
      gate_type  <= gt_n;
    end
  end

  // Bit i of expected is what encoding i would output for the current vector.
  assign expected = {|vec, ~^vec, ^vec, &vec};
  assign sampled  = cand & ~(expected ^ {4{probe_in}});

  always_comb begin
    state_n = state;
    vec_n   = vec;
    cnt_n   = cnt;
    cand_n  = cand;
    cands_n = candidates;
    tv_n    = type_valid;
    gt_n    = gate_type;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = WAIT;
          vec_n   = '0;
          cnt_n   = CW'(SETTLE);
          cand_n  = 4'b1111;
          cands_n = 4'b1111;
          tv_n    = 1'b0;
          gt_n    = 2'b00;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          cand_n = sampled;
          if (vec == LAST_VEC) begin
            // Results are latched from the final sample so they are valid while done is high.
            state_n = FINISH;
            cands_n = sampled;
            tv_n    = $onehot(sampled);
            case (sampled)
              4'b0010: gt_n = 2'b01;
              4'b0100: gt_n = 2'b10;
              4'b1000: gt_n = 2'b11;
              default: gt_n = 2'b00;
            endcase
          end else begin
            vec_n = vec + N'(1);
            cnt_n = CW'(SETTLE);
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == WAIT);
  assign done      = (state == FINISH);
  assign probe_out = busy ? vec : '0;

endmodule

// File: tb/tb_gate_type_detector.sv
// Directed bench: a behavioural gate model answers the probe, and each task checks timing
// and the identification result against hand-computed values.
module tb_gate_type_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] probe_out_a;
  logic       probe_in_a;
  logic       busy_a, done_a, type_valid_a;
  logic [1:0] gate_type_a;
  logic [3:0] candidates_a;
  logic [3:0] probe_out_b;
  logic       probe_in_b;
  logic       busy_b, done_b, type_valid_b;
  logic [1:0] gate_type_b;
  logic [3:0] candidates_b;

  int passed = 0;
  int total  = 0;
  int model  = 0;

  always #5 clk = ~clk;

  gate_type_detector #(.N(2), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .probe_out(probe_out_a), .probe_in(probe_in_a),
    .busy(busy_a), .done(done_a), .type_valid(type_valid_a), .gate_type(gate_type_a),
    .candidates(candidates_a)
  );

  gate_type_detector #(.N(4), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .probe_out(probe_out_b), .probe_in(probe_in_b),
    .busy(busy_b), .done(done_b), .type_valid(type_valid_b), .gate_type(gate_type_b),
    .candidates(candidates_b)
  );

  // Model codes: 0 AND, 1 XOR, 2 XNOR, 3 OR, 4 stuck-at-0, 5 stuck-at-1.
  always_comb begin
    case (model)
      0:       probe_in_a = &probe_out_a;
      1:       probe_in_a = ^probe_out_a;
      2:       probe_in_a = ~^probe_out_a;
      3:       probe_in_a = |probe_out_a;
      5:       probe_in_a = 1'b1;
      default: probe_in_a = 1'b0;
    endcase
  end
  assign probe_in_b = ~^probe_out_b;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int m, input logic [3:0] exp_cand, input logic exp_tv,
                           input logic [1:0] exp_gt, input string name);
    int   done_cycle;
    logic seq_ok;
    logic [1:0] ev;
    model = m;
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    done_cycle = 0;
    seq_ok = 1'b1;
    for (int c = 1; c <= 14 && done_cycle == 0; c++) begin
      if (c == 1) begin
        total++;
        if (busy_a !== 1'b1 || candidates_a !== 4'b1111 || type_valid_a !== 1'b0)
          $display("[TB] FAIL %s accept: busy=%b cand=%b tv=%b, want 1/1111/0", name, busy_a, candidates_a, type_valid_a);
        else passed++;
      end
      if (done_a === 1'b1) done_cycle = c;
      else begin
        ev = 2'((c - 1) / 2);
        if (c > 8 || probe_out_a !== ev) seq_ok = 1'b0;
        next_cycle();
      end
    end
    total++;
    if (done_cycle != 9) $display("[TB] FAIL %s done_cycle: got %0d want 9", name, done_cycle);
    else passed++;
    total++;
    if (!seq_ok) $display("[TB] FAIL %s probe_seq: got mismatch want 00,00,01,01,10,10,11,11", name);
    else passed++;
    total++;
    if (busy_a !== 1'b0 || candidates_a !== exp_cand || type_valid_a !== exp_tv || gate_type_a !== exp_gt)
      $display("[TB] FAIL %s result: busy=%b cand=%b tv=%b gt=%b, want 0/%b/%b/%b",
               name, busy_a, candidates_a, type_valid_a, gate_type_a, exp_cand, exp_tv, exp_gt);
    else passed++;
    next_cycle();
    total++;
    if (done_a !== 1'b0 || candidates_a !== exp_cand || gate_type_a !== exp_gt)
      $display("[TB] FAIL %s hold: done=%b cand=%b gt=%b, want 0/%b/%b", name, done_a, candidates_a, gate_type_a, exp_cand, exp_gt);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b1;
    next_cycle();
    next_cycle();
    total++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || probe_out_a !== 2'b00 || type_valid_a !== 1'b0 ||
        gate_type_a !== 2'b00 || candidates_a !== 4'b0000)
      $display("[TB] FAIL reset_state: busy=%b done=%b probe=%b tv=%b gt=%b cand=%b, want all zero",
               busy_a, done_a, probe_out_a, type_valid_a, gate_type_a, candidates_a);
    else passed++;
    start_a = 1'b0;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_gate_types();
    run_sweep(0, 4'b0001, 1'b1, 2'b00, "and");
    run_sweep(1, 4'b0010, 1'b1, 2'b01, "xor");
    run_sweep(2, 4'b0100, 1'b1, 2'b10, "xnor");
    run_sweep(3, 4'b1000, 1'b1, 2'b11, "or");
  endtask

  task automatic test_stuck();
    run_sweep(4, 4'b0000, 1'b0, 2'b00, "stuck0");
    run_sweep(5, 4'b0000, 1'b0, 2'b00, "stuck1");
  endtask

  task automatic test_reset_mid_sweep();
    logic saw_done;
    model = 3;
    start_a = 1'b1;
    next_cycle();
    start_a = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    total++;
    if (busy_a !== 1'b0 || probe_out_a !== 2'b00 || candidates_a !== 4'b0000)
      $display("[TB] FAIL midreset_abort: busy=%b probe=%b cand=%b, want 0/00/0000", busy_a, probe_out_a, candidates_a);
    else passed++;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done_a === 1'b1) saw_done = 1'b1;
      next_cycle();
    end
    total++;
    if (saw_done) $display("[TB] FAIL midreset_nodone: got done pulse want none");
    else passed++;
    rst_n = 1'b1;
    next_cycle();
    run_sweep(3, 4'b1000, 1'b1, 2'b11, "restart_or");
  endtask

  task automatic test_back_to_back();
    int n_done;
    int first_done;
    int second_done;
    model = 1;
    start_a = 1'b1;
    next_cycle();
    n_done = 0;
    first_done = 0;
    second_done = 0;
    for (int c = 1; c <= 19; c++) begin
      if (done_a === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
        else second_done = c;
      end
      if (c == 10) begin
        total++;
        if (busy_a !== 1'b0 || type_valid_a !== 1'b1 || gate_type_a !== 2'b01)
          $display("[TB] FAIL b2b_idle: busy=%b tv=%b gt=%b, want 0/1/01", busy_a, type_valid_a, gate_type_a);
        else passed++;
      end
      if (c == 11) begin
        total++;
        if (busy_a !== 1'b1 || candidates_a !== 4'b1111 || type_valid_a !== 1'b0 || gate_type_a !== 2'b00)
          $display("[TB] FAIL b2b_clear: busy=%b cand=%b tv=%b gt=%b, want 1/1111/0/00",
                   busy_a, candidates_a, type_valid_a, gate_type_a);
        else passed++;
      end
      if (c == 19) begin
        total++;
        if (type_valid_a !== 1'b1 || gate_type_a !== 2'b01 || candidates_a !== 4'b0010)
          $display("[TB] FAIL b2b_result: tv=%b gt=%b cand=%b, want 1/01/0010", type_valid_a, gate_type_a, candidates_a);
        else passed++;
      end else next_cycle();
    end
    total++;
    if (n_done != 2 || first_done != 9 || second_done != 19)
      $display("[TB] FAIL b2b_done: count=%0d at %0d,%0d want 2 at 9,19", n_done, first_done, second_done);
    else passed++;
    start_a = 1'b0;
    next_cycle();
  endtask

  task automatic test_wide_no_settle();
    int   done_cycle;
    logic seq_ok;
    start_b = 1'b1;
    next_cycle();
    start_b = 1'b0;
    done_cycle = 0;
    seq_ok = 1'b1;
    for (int c = 1; c <= 24 && done_cycle == 0; c++) begin
      if (done_b === 1'b1) done_cycle = c;
      else begin
        if (c > 16 || probe_out_b !== 4'(c - 1)) seq_ok = 1'b0;
        next_cycle();
      end
    end
    total++;
    if (done_cycle != 17) $display("[TB] FAIL wide_done_cycle: got %0d want 17", done_cycle);
    else passed++;
    total++;
    if (!seq_ok) $display("[TB] FAIL wide_probe_seq: got mismatch want 0..15 one per cycle");
    else passed++;
    total++;
    if (type_valid_b !== 1'b1 || gate_type_b !== 2'b10 || candidates_b !== 4'b0100)
      $display("[TB] FAIL wide_result: tv=%b gt=%b cand=%b, want 1/10/0100", type_valid_b, gate_type_b, candidates_b);
    else passed++;
    next_cycle();
  endtask

  initial begin
    #1;
    test_reset();
    test_gate_types();
    test_stuck();
    test_reset_mid_sweep();
    test_back_to_back();
    test_wide_no_settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
